// File: rtl/buf_ctrl_pkg.sv
// Shared constants for the ping-pong frame buffer controller and the buffer models.
package buf_ctrl_pkg;

    localparam int NPIX_DEF = 100;
    localparam int AW_DEF   = 20;

    localparam logic RD_IDLE = 1'b0;
    localparam logic RD_SCAN = 1'b1;

    // Index of the last pixel of a frame.
    function automatic int last_idx(input int npix);
        return npix - 1;
    endfunction

endpackage

// File: rtl/buf_pingpong_ctrl_frame_addr_ctr.sv
// Mod-NPIX pixel address counter: clr has priority over inc; wrap flags the last pixel.
module frame_addr_ctr
    import buf_ctrl_pkg::*;
#(
    parameter int NPIX = NPIX_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          inc,
    input  logic          clr,
    output logic [AW-1:0] addr,
    output logic          wrap
);

    localparam logic [AW-1:0] LAST_A = AW'(last_idx(NPIX));

    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;

    // Next count: clear, advance, or wrap back to pixel 0 after the last pixel.
    always_comb begin
        wrap  = (cnt_q == LAST_A);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = wrap ? '0 : cnt_q + AW'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign addr = cnt_q;

endmodule

// File: rtl/buf_pingpong_ctrl.sv
// Ping-pong frame buffer controller: producer fills one buffer while the display
// scans the other; roles swap only on a frame boundary.
module buf_pingpong_ctrl
    import buf_ctrl_pkg::*;
#(
    parameter int NPIX = NPIX_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic          we0,
    output logic          we1,
    output logic [AW-1:0] waddr,
    input  logic          rd_req,
    output logic          re0,
    output logic          re1,
    output logic [AW-1:0] raddr,
    output logic          rd_valid,
    output logic          rd_sel,
    output logic          rd_sof,
    output logic          rd_eof,
    output logic          frame_swap,
    output logic          underrun
);

    logic wr_buf_q, wr_buf_d;
    logic wr_full_q, wr_full_d;
    logic rd_state_q, rd_state_d;
    logic rd_valid_q, rd_valid_d;
    logic rd_sel_q, rd_sel_d;
    logic rd_sof_q, rd_sof_d;
    logic rd_eof_q, rd_eof_d;
    logic frame_swap_q, frame_swap_d;
    logic underrun_q, underrun_d;

    logic          wa;
    logic          ra;
    logic          rd_buf;
    logic          swap;
    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] rd_cnt;
    logic          wr_wrap;
    logic          rd_wrap;

    frame_addr_ctr #(.NPIX(NPIX), .AW(AW)) u_wr_ctr (
        .clock  (clock),
        .resetn (resetn),
        .inc    (wa),
        .clr    (swap),
        .addr   (wr_cnt),
        .wrap   (wr_wrap)
    );

    frame_addr_ctr #(.NPIX(NPIX), .AW(AW)) u_rd_ctr (
        .clock  (clock),
        .resetn (resetn),
        .inc    (ra),
        .clr    (swap),
        .addr   (rd_cnt),
        .wrap   (rd_wrap)
    );

    // Handshakes and buffer strobes; everything is gated by resetn so reset forces all pins low.
    always_comb begin
        rd_buf   = ~wr_buf_q;
        wr_ready = resetn & ~wr_full_q;
        wa       = wr_valid & wr_ready;
        ra       = rd_req & (rd_state_q == RD_SCAN) & resetn;
        we0      = wa & ~wr_buf_q;
        we1      = wa & wr_buf_q;
        re0      = ra & ~rd_buf;
        re1      = ra & rd_buf;
        waddr    = wr_cnt;
        raddr    = rd_cnt;
        // A full write buffer is handed over immediately if nobody is reading,
        // otherwise only as the reader takes the last pixel of its frame.
        swap     = wr_full_q & ((rd_state_q == RD_IDLE) | (ra & rd_wrap));
    end

    // Next state of buffer roles, fill flag, reader FSM and the one-cycle-late read flags.
    always_comb begin
        wr_buf_d     = wr_buf_q;
        wr_full_d    = wr_full_q;
        rd_state_d   = rd_state_q;
        rd_sel_d     = rd_sel_q;
        rd_valid_d   = ra;
        rd_sof_d     = ra & (rd_cnt == '0);
        rd_eof_d     = ra & rd_wrap;
        frame_swap_d = swap;
        underrun_d   = rd_req & (rd_state_q == RD_IDLE) & resetn;

        // Select is captured before any toggle, so the last pixel of a frame
        // still comes from the buffer it was read from.
        if (ra) begin
            rd_sel_d = rd_buf;
        end

        if (wa && wr_wrap) begin
            wr_full_d = 1'b1;
        end

        if (swap) begin
            wr_buf_d   = ~wr_buf_q;
            wr_full_d  = 1'b0;
            rd_state_d = RD_SCAN;
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_buf_q     <= 1'b0;
            wr_full_q    <= 1'b0;
            rd_state_q   <= RD_IDLE;
            rd_valid_q   <= 1'b0;
            rd_sel_q     <= 1'b0;
            rd_sof_q     <= 1'b0;
            rd_eof_q     <= 1'b0;
            frame_swap_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            wr_buf_q     <= wr_buf_d;
            wr_full_q    <= wr_full_d;
            rd_state_q   <= rd_state_d;
            rd_valid_q   <= rd_valid_d;
            rd_sel_q     <= rd_sel_d;
            rd_sof_q     <= rd_sof_d;
            rd_eof_q     <= rd_eof_d;
            frame_swap_q <= frame_swap_d;
            underrun_q   <= underrun_d;
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_sel     = rd_sel_q;
    assign rd_sof     = rd_sof_q;
    assign rd_eof     = rd_eof_q;
    assign frame_swap = frame_swap_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_buf_pingpong_ctrl.sv
// Scoreboard bench for buf_pingpong_ctrl: a frame-level reference model predicts every
// strobe and pulse; a monitor pops and compares whenever the DUT presents one.
module tb_buf_pingpong_ctrl;

    localparam int N  = 100;
    localparam int AW = 20;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          wr_valid = 1'b0;
    logic          rd_req = 1'b0;
    logic          wr_ready, we0, we1, re0, re1;
    logic [AW-1:0] waddr, raddr;
    logic          rd_valid, rd_sel, rd_sof, rd_eof, frame_swap, underrun;

    buf_pingpong_ctrl #(.NPIX(N), .AW(AW)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .we0        (we0),
        .we1        (we1),
        .waddr      (waddr),
        .rd_req     (rd_req),
        .re0        (re0),
        .re1        (re1),
        .raddr      (raddr),
        .rd_valid   (rd_valid),
        .rd_sel     (rd_sel),
        .rd_sof     (rd_sof),
        .rd_eof     (rd_eof),
        .frame_swap (frame_swap),
        .underrun   (underrun)
    );

    always #5 clock = ~clock;

    typedef struct {
        int cyc;
        int b;
        int addr;
        int sof;
        int eof;
    } ev_t;

    ev_t q_wr[$];
    ev_t q_re[$];
    ev_t q_val[$];
    int  q_swp[$];
    int  q_und[$];
    int  q_rdy[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cur_cyc = 0;

    // Reference model: which buffer the producer owns, how far each side is
    // through its frame, whether a finished frame is waiting, whether display is live.
    int m_wbuf = 0;
    int m_wpos = 0;
    int m_rpos = 0;
    bit m_full = 1'b0;
    bit m_scan = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cur_cyc);
        end
    endtask

    task automatic unexpected(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: DUT event with nothing expected (cycle %0d)", nm, cur_cyc);
    endtask

    // Predict this cycle's visible strobes and next cycle's pulses, then advance the frame state.
    task automatic model_cycle(input bit wv, input bit rr, input bit rn);
        bit rdy, wa, ra, swp;
        if (!rn) begin
            q_rdy.push_back(0);
            m_wbuf = 0; m_wpos = 0; m_rpos = 0; m_full = 0; m_scan = 0;
            return;
        end
        rdy = !m_full;
        wa  = wv && rdy;
        ra  = rr && m_scan;
        q_rdy.push_back(int'(rdy));
        if (wa) q_wr.push_back('{cur_cyc, m_wbuf, m_wpos, 0, 0});
        if (ra) begin
            q_re.push_back('{cur_cyc, 1 - m_wbuf, m_rpos, 0, 0});
            q_val.push_back('{cur_cyc + 1, 1 - m_wbuf, 0, int'(m_rpos == 0), int'(m_rpos == N - 1)});
        end
        if (rr && !m_scan) q_und.push_back(cur_cyc + 1);
        // A finished frame goes to the display when it is idle or finishing its current frame.
        swp = m_full && (!m_scan || (ra && m_rpos == N - 1));
        if (wa) begin
            m_wpos++;
            if (m_wpos == N) begin
                m_wpos = 0;
                m_full = 1'b1;
            end
        end
        if (ra) m_rpos = (m_rpos + 1) % N;
        if (swp) begin
            m_wbuf = 1 - m_wbuf;
            m_full = 1'b0;
            m_wpos = 0;
            m_rpos = 0;
            m_scan = 1'b1;
            q_swp.push_back(cur_cyc + 1);
        end
    endtask

    task automatic step(input bit wv, input bit rr, input bit rn);
        @(posedge clock);
        #1;
        wr_valid = wv;
        rd_req   = rr;
        resetn   = rn;
        cur_cyc++;
        model_cycle(wv, rr, rn);
    endtask

    function automatic bit coin(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    // Monitor: compare whatever the DUT shows this cycle against the scoreboard queues.
    always @(negedge clock) begin
        ev_t e;
        int  c;
        if (q_rdy.size() > 0) begin
            c = q_rdy.pop_front();
            chk("wr_ready", {31'd0, wr_ready}, c);
        end
        if (we0 === 1'b1 || we1 === 1'b1) begin
            if (q_wr.size() == 0) unexpected("write");
            else begin
                e = q_wr.pop_front();
                chk("write_cycle", cur_cyc, e.cyc);
                chk("write_we10", {30'd0, we1, we0}, (e.b != 0) ? 2 : 1);
                chk("write_waddr", {12'd0, waddr}, e.addr);
            end
        end
        if (re0 === 1'b1 || re1 === 1'b1) begin
            if (q_re.size() == 0) unexpected("read_strobe");
            else begin
                e = q_re.pop_front();
                chk("read_cycle", cur_cyc, e.cyc);
                chk("read_re10", {30'd0, re1, re0}, (e.b != 0) ? 2 : 1);
                chk("read_raddr", {12'd0, raddr}, e.addr);
            end
        end
        if (rd_valid === 1'b1) begin
            if (q_val.size() == 0) unexpected("rd_valid");
            else begin
                e = q_val.pop_front();
                chk("rdv_cycle", cur_cyc, e.cyc);
                chk("rd_sel", {31'd0, rd_sel}, e.b);
                chk("rd_sof", {31'd0, rd_sof}, e.sof);
                chk("rd_eof", {31'd0, rd_eof}, e.eof);
            end
        end
        if (frame_swap === 1'b1) begin
            if (q_swp.size() == 0) unexpected("frame_swap");
            else begin
                c = q_swp.pop_front();
                chk("swap_cycle", cur_cyc, c);
            end
        end
        if (underrun === 1'b1) begin
            if (q_und.size() == 0) unexpected("underrun");
            else begin
                c = q_und.pop_front();
                chk("underrun_cycle", cur_cyc, c);
            end
        end
    end

    // Hold reset with both requests active and confirm every output is low.
    task automatic reset_and_check();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        @(negedge clock);
        chk("rst_outs", {20'd0, wr_ready, we0, we1, re0, re1, rd_valid, rd_sel,
                         rd_sof, rd_eof, frame_swap, underrun, 1'b0}, 0);
        chk("rst_waddr", {12'd0, waddr}, 0);
        chk("rst_raddr", {12'd0, raddr}, 0);
    endtask

    initial begin
        int guard;
        reset_and_check();

        // Nothing written yet: display requests underrun.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        // One full frame into buffer 0, then the first reads.
        for (int i = 0; i < N; i++) step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        // Re-align both sides to pixel 0 via a fresh reset and first frame.
        reset_and_check();
        for (int i = 0; i < N; i++) step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        // Writer and reader in lockstep: last write and last read coincide.
        for (int i = 0; i < N; i++) step(1'b1, 1'b1, 1'b1);
        // Reader repeats the old frame; swap lands on its last pixel, then repeats twice more.
        for (int i = 0; i < 3 * N + 5; i++) step(1'b0, 1'b1, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) step(coin(70), coin(60), 1'b1);

        // Reset in the middle of a frame, with the display scanning.
        guard = 0;
        while (!(m_wpos == 57 && !m_full && m_scan) && guard < 3000) begin
            step(m_wpos != 57 || m_full, coin(60), 1'b1);
            guard++;
        end
        chk("align_timeout", guard < 3000, 1);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 2000; i++) step(coin(65), coin(55), 1'b1);

        // Drain pending pulses, then nothing may remain expected.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
        @(negedge clock);
        #1;
        chk("left_wr", q_wr.size(), 0);
        chk("left_re", q_re.size(), 0);
        chk("left_val", q_val.size(), 0);
        chk("left_swp", q_swp.size(), 0);
        chk("left_und", q_und.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
